multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller.sv | 171 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle KGP-RISC control unit: steps each instruction through FETCH/DECODE/EXEC/MEM/WB/BRANCH.
// Optional feature macro: ILLEGAL_TRAP_EN (undefined opcodes enter a sticky TRAP state).
module multicycle_controller #(
  parameter int OPCODE_W = 6,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                ir_write,
  output logic                pc_inc,
  output logic                pc_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem2reg,
  output logic                alu_src,
  output logic                lbl_sel,
  output logic                jmp_sel,
  output logic                bus_err,
  output logic [2:0]          state_o,
  output logic                illegal_op
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    BRANCH = 3'd6,
    TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CL_UNDEF, CL_RTYPE, CL_IMM, CL_LW, CL_SW, CL_COND, CL_BR, CL_BL, CL_LBL
  } opClass_t;

  state_t               state, nextState;
  logic [CNT_W-1:0]     waitCnt, waitCntNext;
  logic [OPCODE_W-1:0]  opLatch;
  opClass_t             decCls, latCls;
  logic                 waiting, accessReady, timeout;

  // Only the low 6 bits name an opcode; any set upper bit makes it undefined.
  function automatic opClass_t classify(input logic [OPCODE_W-1:0] op);
    logic [5:0] low;
    low = op[5:0];
    if ((op >> 6) != '0) return CL_UNDEF;
    casez (low)
      6'b000000:                     return CL_RTYPE;
      6'b001000, 6'b001001:          return CL_IMM;
      6'b010000:                     return CL_LW;
      6'b011000:                     return CL_SW;
      6'b101000, 6'b101001, 6'b101010: return CL_COND;
      6'b100000:                     return CL_BR;
      6'b101011:                     return CL_BL;
      6'b110???:                     return CL_LBL;
      default:                       return CL_UNDEF;
    endcase
  endfunction

  assign decCls  = classify(opcode);
  assign latCls  = classify(opLatch);
  assign state_o = state;

  assign waiting     = (state == FETCH) || (state == MEM);
  assign accessReady = (state == FETCH) ? imem_ready : dmem_ready;
  // A ready on the final wait cycle takes precedence over the timeout.
  assign timeout     = waiting && !accessReady && (waitCnt == CNT_W'(WAIT_MAX - 1));
  assign waitCntNext = (waiting && !accessReady && !timeout) ? waitCnt + 1'b1 : '0;
  assign bus_err     = timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      waitCnt <= '0;
      opLatch <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= waitCntNext;
      if (state == DECODE) opLatch <= opcode;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegalReg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegalReg <= 1'b0;
    else if (state == DECODE && decCls == CL_UNDEF) illegalReg <= 1'b1;
  end
  assign illegal_op = illegalReg;
`else
  assign illegal_op = 1'b0;
`endif

  always_comb begin
    nextState = state;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    pc_inc    = 1'b0;
    pc_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 2'b00;
    mem2reg   = 2'b00;
    alu_src   = 1'b0;
    lbl_sel   = 1'b0;
    jmp_sel   = 1'b0;
    case (state)
      IDLE: nextState = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write  = 1'b1;
          pc_inc    = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        case (decCls)
          CL_RTYPE, CL_IMM, CL_LW, CL_SW:  nextState = EXEC;
          CL_COND, CL_BR, CL_BL, CL_LBL:   nextState = BRANCH;
`ifdef ILLEGAL_TRAP_EN
          default:                         nextState = TRAP;
`else
          default:                         nextState = FETCH;
`endif
        endcase
      end
      EXEC: begin
        alu_src   = (latCls != CL_RTYPE);
        nextState = (latCls == CL_LW || latCls == CL_SW) ? MEM : WB;
      end
      MEM: begin
        mem_read  = (latCls == CL_LW);
        mem_write = (latCls == CL_SW);
        if (dmem_ready) nextState = (latCls == CL_LW) ? WB : FETCH;
      end
      WB: begin
        reg_write = 1'b1;
        mem2reg   = (latCls == CL_LW) ? 2'b01 : 2'b11;
        nextState = FETCH;
      end
      BRANCH: begin
        // Conditional branches still raise pc_write; the datapath gates it.
        pc_write = 1'b1;
        lbl_sel  = (latCls == CL_LBL);
        jmp_sel  = (latCls == CL_BR);
        if (latCls == CL_BL) begin
          reg_write = 1'b1;
          reg_dst   = 2'b11;
          mem2reg   = 2'b00;
        end
        nextState = FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP:    nextState = TRAP;
`endif
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a per-instruction cycle model fills an expected queue that is replayed
// against the DUT. Compile with ILLEGAL_TRAP_EN defined to exercise the trap build.
module tb_multicycle_controller;

  localparam int WAIT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       imem_ready, dmem_ready;
  logic       imem_req, ir_write, pc_inc, pc_write, mem_read, mem_write, reg_write;
  logic [1:0] reg_dst, mem2reg;
  logic       alu_src, lbl_sel, jmp_sel, bus_err, illegal_op;
  logic [2:0] state_o;

  multicycle_controller #(.OPCODE_W(6), .WAIT_MAX(WAIT_MAX), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_inc(pc_inc), .pc_write(pc_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem2reg(mem2reg), .alu_src(alu_src),
    .lbl_sel(lbl_sel), .jmp_sel(jmp_sel), .bus_err(bus_err),
    .state_o(state_o), .illegal_op(illegal_op)
  );

  // clock/reset block
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       imemReq, irWrite, pcInc, pcWrite, memRead, memWrite, regWrite;
    logic [1:0] regDst, mem2reg;
    logic       aluSrc, lblSel, jmpSel, busErr, illegalOp;
  } outs_t;

  typedef struct packed {
    logic       imemRdy, dmemRdy;
    logic [5:0] op;
    outs_t      o;
  } cyc_t;

  outs_t obs;
  assign obs = {state_o, imem_req, ir_write, pc_inc, pc_write, mem_read, mem_write, reg_write,
                reg_dst, mem2reg, alu_src, lbl_sel, jmp_sel, bus_err, illegal_op};

  cyc_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    needIdle = 1'b0;
  bit    trapped = 1'b0;
  string tag = "init";
  outs_t zeroOuts = '0;

  // One cycle with no strobes; inputs the DUT must ignore are randomized.
  function automatic cyc_t mkCyc(input int st);
    cyc_t c;
    c = '0;
    c.o.st    = 3'(st);
    c.imemRdy = 1'($urandom_range(0, 1));
    c.dmemRdy = 1'($urandom_range(0, 1));
    c.op      = 6'($urandom_range(0, 63));
    return c;
  endfunction

  // Reference model: expected cycles for one instruction with fw fetch stalls and mw memory stalls.
  task automatic modelInstr(input int op, input int fw, input int mw);
    cyc_t c;
    bit isBranch;
    for (int k = 1; k <= fw; k++) begin
      c = mkCyc(1); c.imemRdy = 1'b0; c.o.imemReq = 1'b1;
      c.o.busErr = (k % WAIT_MAX == 0);
      exp_q.push_back(c);
    end
    c = mkCyc(1); c.imemRdy = 1'b1;
    c.o.imemReq = 1'b1; c.o.irWrite = 1'b1; c.o.pcInc = 1'b1;
    exp_q.push_back(c);
    c = mkCyc(2); c.op = 6'(op);
    exp_q.push_back(c);
    isBranch = (op >= 40 && op <= 43) || op == 32 || (op / 8) == 6;
    if (op == 0 || op == 8 || op == 9) begin
      c = mkCyc(3); c.o.aluSrc = (op != 0); exp_q.push_back(c);
      c = mkCyc(5); c.o.regWrite = 1'b1; c.o.mem2reg = 2'b11; exp_q.push_back(c);
    end else if (op == 16 || op == 24) begin
      c = mkCyc(3); c.o.aluSrc = 1'b1; exp_q.push_back(c);
      for (int k = 1; k <= mw + 1; k++) begin
        c = mkCyc(4); c.dmemRdy = (k == mw + 1);
        c.o.memRead  = (op == 16);
        c.o.memWrite = (op == 24);
        c.o.busErr   = (k <= mw) && (k % WAIT_MAX == 0);
        exp_q.push_back(c);
      end
      if (op == 16) begin
        c = mkCyc(5); c.o.regWrite = 1'b1; c.o.mem2reg = 2'b01; exp_q.push_back(c);
      end
    end else if (isBranch) begin
      c = mkCyc(6); c.o.pcWrite = 1'b1;
      c.o.lblSel = ((op / 8) == 6);
      c.o.jmpSel = (op == 32);
      if (op == 43) begin
        c.o.regWrite = 1'b1; c.o.regDst = 2'b11; c.o.mem2reg = 2'b00;
      end
      exp_q.push_back(c);
    end else begin
`ifdef ILLEGAL_TRAP_EN
      for (int k = 0; k < 3; k++) begin
        c = mkCyc(7); c.o.illegalOp = 1'b1; exp_q.push_back(c);
      end
      trapped = 1'b1;
`endif
    end
  endtask

  // Asynchronous reset mid-cycle: outputs must drop to zero before any clock edge.
  task automatic doReset();
    #2 rst = 1'b1;
    #1;
    vectors++;
    assert (obs === zeroOuts) else begin
      miscompares++;
      $error("FAIL reset[%s] observed=%h expected=%h", tag, obs, zeroOuts);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    needIdle = 1'b1;
  endtask

  // driver: replays the expected queue, checking on the falling edge
  task automatic drain(input int abortMem);
    cyc_t c;
    int memSeen;
    memSeen = 0;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      imem_ready = c.imemRdy;
      dmem_ready = c.dmemRdy;
      opcode     = c.op;
      @(negedge clk);
      vectors++;
      assert (obs === c.o) else begin
        miscompares++;
        $error("FAIL cycle[%s] observed=%h expected=%h", tag, obs, c.o);
      end
      @(posedge clk); #1;
      if (c.o.st == 3'd4) memSeen++;
      if (abortMem > 0 && memSeen == abortMem) begin
        exp_q.delete();
        doReset();
      end
    end
  endtask

  task automatic runInstr(input string t, input int op, input int fw, input int mw, input int abortMem);
    tag = t;
    if (needIdle) begin
      exp_q.push_back(mkCyc(0));
      needIdle = 1'b0;
    end
    modelInstr(op, fw, mw);
    drain(abortMem);
    if (trapped) begin
      doReset();
      trapped = 1'b0;
    end
  endtask

  int opTab[18] = '{0, 8, 9, 16, 24, 32, 40, 41, 42, 43, 48, 49, 55, 63, 1, 17, 44, 56};
  int fwTab[9]  = '{0, 0, 1, 2, 3, 14, 15, 29, 30};
  int mwTab[6]  = '{0, 1, 3, 14, 15, 20};

  initial begin
    rst = 1'b0; opcode = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    tag = "reset";
    doReset();
    runInstr("rtype",     0,  0,  0, 0);
    runInstr("lw_wait3",  16, 0,  3, 0);
    runInstr("sw_wait2",  24, 0,  2, 0);
    runInstr("bl",        43, 0,  0, 0);
    runInstr("bz",        49, 0,  0, 0);
    runInstr("br",        32, 0,  0, 0);
    runInstr("addi_f30",  8,  30, 0, 0);
    runInstr("ready_wins", 9, 14, 14, 0);
    runInstr("lw_abort",  16, 0,  10, 3);
    runInstr("undef63",   63, 0,  0, 0);
    runInstr("post_undef", 0, 0,  0, 0);
    for (int i = 0; i < 40; i++) begin
      runInstr("random",
               opTab[$urandom_range(0, 17)],
               fwTab[$urandom_range(0, 8)],
               mwTab[$urandom_range(0, 5)], 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
